bcd_display_ctrl: RTL and testbench
===================================

BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary input width in bits.
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD digits produced; elaboration SHALL fail if 10^DIGITS <= 2^WIDTH-1.
REQ-003 SHALL have parameter BLANK_CODE, default 4'hF, digit code driven to a seven_segment instance to blank it.
REQ-004 SHALL have one clock and a synchronous active-low reset: clk (input, 1, rising-edge clock) and reset_n (input, 1, synchronous active-low reset).
REQ-005 SHALL have port in_valid, input, 1 bit: bin is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: controller can accept bin.
REQ-007 SHALL have port bin, input, WIDTH bits: unsigned binary value to convert.
REQ-008 SHALL have port lz_blank, input, 1 bit: blank leading zeros; sampled with bin.
REQ-009 SHALL have port bcd, output, 4*DIGITS bits: packed BCD result, digit 0 in [3:0].
REQ-010 SHALL have port digit, output, 4*DIGITS bits: per-display codes (BCD or BLANK_CODE) for the seven_segment inputs.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when bcd/digit update.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, CONVERT, LOAD.
REQ-013 in_ready SHALL be 1 exactly when state is IDLE (combinational from state).
REQ-014 The block SHALL accept a value on a rising edge with in_valid=1 and in_ready=1; it SHALL latch bin into a shift register and lz_blank into a flag, clear the BCD scratch register, load an iteration counter with WIDTH, and go to CONVERT.
REQ-015 In CONVERT, each cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit, then decrement the counter.
REQ-016 When the counter reaches 0, the FSM SHALL go to LOAD; after WIDTH CONVERT cycles, CONVERT SHALL go to LOAD.
REQ-017 In LOAD, the block SHALL register the scratch into bcd and the blanked codes into digit, assert done for that one cycle, and go to IDLE.
REQ-018 Latency SHALL be fixed at WIDTH+1 cycles from the accepting edge to the edge updating bcd/digit/done; the next accept SHALL be possible on the following edge, giving a throughput of one value per WIDTH+2 cycles.
REQ-019 bcd and digit SHALL hold their previous values throughout CONVERT, so displays never show partial results.
REQ-020 Blanking: with the flag set, digits above the most significant nonzero digit SHALL be BLANK_CODE; digit 0 SHALL never be blanked; with the flag clear, digit SHALL equal bcd.
REQ-021 in_valid while not IDLE SHALL be ignored; bin/lz_blank changes after acceptance SHALL not affect the result.
REQ-022 Scratch digits SHALL never exceed 9 after any shift; no overflow path exists given REQ-002.
REQ-023 done SHALL not be asserted in any state other than LOAD.

Reset
REQ-024 When reset_n=0 at a rising edge, the block SHALL set state=IDLE, bcd=0, all digit fields=BLANK_CODE, done=0, and clear the counter, scratch register and flag.
REQ-025 Reset mid-CONVERT or in LOAD SHALL abort with no done pulse and no output update beyond the reset values.
REQ-026 in_ready SHALL be 1 in the first cycle after reset_n returns high.

Verification
REQ-027 Accept bin=255, lz_blank=0 -> after 9 cycles bcd=12'h255, digit=12'h255, done high for 1 cycle.
REQ-028 Accept bin=7, lz_blank=1 -> bcd=12'h007, digit=12'hFF7; then bin=0, lz_blank=1 -> digit=12'hFF0.
REQ-029 Accept bin=100, lz_blank=1 -> digit=12'h100 (interior zeros not blanked); bin=100, lz_blank=0 -> identical.
REQ-030 Hold in_valid=1 with bin=42, then 199, across cycles -> in_ready=0 for 9 cycles; 199 is accepted only on the edge after done; digit goes 042/F42 then 199 with no intermediate value.
REQ-031 Apply reset_n=0 at CONVERT cycle 4 of bin=128 -> no done; bcd=0, digit=12'hFFF; in_ready=1 in the next cycle.
REQ-032 Exhaustive sweep of bin 0..255, both lz_blank values -> bcd matches a decimal reference model, and latency is 9 cycles for every value.

Source files
------------

// File: rtl/bcd_display_if.sv
// Handshake and result bundle between a producer of binary values and the
// BCD display controller. The producer drives the master side; the
// controller implements the slave side.
interface bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin;
  logic                  lz_blank;
  logic [4*DIGITS-1:0]   bcd;
  logic [4*DIGITS-1:0]   digit;
  logic                  done;

  modport master (
    output in_valid,
    output bin,
    output lz_blank,
    input  in_ready,
    input  bcd,
    input  digit,
    input  done
  );

  modport slave (
    input  in_valid,
    input  bin,
    input  lz_blank,
    output in_ready,
    output bcd,
    output digit,
    output done
  );

endinterface

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding a bank of
// seven-segment decoders. One value is converted per WIDTH+2 cycles; the
// bcd/digit outputs only change on completion so the displays never show
// intermediate scratch contents. Optional leading-zero blanking replaces
// upper zero digits with BLANK_CODE.
module bcd_display_ctrl #(
  parameter int         WIDTH      = 8,
  parameter int         DIGITS     = 3,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input logic          clk,
  input logic          reset_n,
  bcd_display_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

  // The digit count must be able to hold the largest binary input, or the
  // top scratch digit would overflow during the final shifts.
  generate
    if (WIDTH < 1 || WIDTH > 63 || DIGITS < 1 || DIGITS > 19 ||
        pow10(DIGITS) <= MAX_BIN) begin : g_param_check
      $error("bcd_display_ctrl: DIGITS too small for WIDTH (or WIDTH out of range)");
    end
  endgenerate

  // Shift-and-add-3 correction: any digit >= 5 would become >= 10 after the
  // upcoming doubling, so pre-add 3 to make it carry into the next digit.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Replace zero digits above the most significant nonzero digit with the
  // blank code. Digit 0 is always shown so a value of 0 displays "0".
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] b,
                                                     input logic            lz);
    logic [BCD_W-1:0] r;
    logic             leading;
    r       = b;
    leading = lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (b[4*i +: 4] != 4'd0) leading = 1'b0;
      if (leading) r[4*i +: 4] = BLANK_CODE;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [WIDTH-1:0]        shift_reg;
  logic [BCD_W-1:0]        scratch;
  logic [CNT_W-1:0]        cnt;
  logic                    lz_flag;
  logic [BCD_W-1:0]        bcd_reg;
  logic [BCD_W-1:0]        digit_reg;
  logic                    done_reg;
  logic                    accept;
  logic [BCD_W+WIDTH-1:0]  shifted;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE);
  assign bus.bcd      = bcd_reg;
  assign bus.digit    = digit_reg;
  assign bus.done     = done_reg;

  // One conversion step: correct the scratch digits, then shift the combined
  // {scratch, binary} register left so the next binary MSB enters digit 0.
  always_comb begin
    shifted = {add3_adjust(scratch), shift_reg} << 1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; CONVERT leaves on the step that brings the counter to 0.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = CONVERT;
      CONVERT: if (cnt == CNT_W'(1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in CONVERT, publish results in LOAD.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      lz_flag   <= 1'b0;
      bcd_reg   <= '0;
      digit_reg <= {DIGITS{BLANK_CODE}};
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= bus.bin;
            lz_flag   <= bus.lz_blank;
            scratch   <= '0;
            cnt       <= CNT_W'(WIDTH);
          end
        end
        CONVERT: begin
          {scratch, shift_reg} <= shifted;
          cnt                  <= cnt - CNT_W'(1);
        end
        LOAD: begin
          bcd_reg   <= scratch;
          digit_reg <= blank_leading(scratch, lz_flag);
          done_reg  <= 1'b1;
        end
        default: begin
          done_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl: the driver pushes the decimal
// reference result for each accepted value; a negedge monitor pops on done
// and also checks in_ready timing and that outputs hold between results.
module tb_bcd_display_ctrl;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int LAT    = WIDTH + 1;

  typedef struct {
    logic [11:0] b;
    logic [11:0] d;
    int          edge_n;
    int          val;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   acc_edge = 0;
  bit   have_acc = 0;
  bit   mon_en = 0;
  logic [11:0] last_bcd = 12'h000;
  logic [11:0] last_digit = 12'hFFF;
  exp_t sb[$];

  bcd_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_CODE(4'hF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, req, edge_cnt);
    end
  endtask

  // Decimal reference: split the value into base-10 digits, then blank zeros
  // above the highest nonzero digit when requested.
  function automatic void model(input int v, input bit lz,
                                output logic [11:0] eb, output logic [11:0] ed);
    int d[3];
    int t;
    int msd;
    t = v;
    msd = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = t % 10;
      t = t / 10;
      if (d[i] != 0) msd = i;
    end
    eb = '0;
    ed = '0;
    for (int i = 0; i < 3; i++) begin
      eb[4*i +: 4] = 4'(d[i]);
      ed[4*i +: 4] = (lz && i > msd) ? 4'hF : 4'(d[i]);
    end
  endfunction

  // Offer a value and keep in_valid high until the edge that accepts it.
  task automatic send(input int v, input bit lz);
    int   waitc;
    exp_t e;
    waitc = 0;
    bus.bin = 8'(v);
    bus.lz_blank = lz;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1) begin
      @(posedge clk); #2;
      waitc++;
      if (waitc > 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=busy required=ready value=%0d", v);
        return;
      end
    end
    model(v, lz, e.b, e.d);
    e.edge_n = edge_cnt + 1;
    e.val = v;
    acc_edge = edge_cnt + 1;
    have_acc = 1;
    sb.push_back(e);
    @(posedge clk); #2;
  endtask

  // Monitor: result comparison on done, otherwise outputs must hold.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   busy;
    if (reset_n === 1'b1 && mon_en) begin
      busy = have_acc && edge_cnt >= acc_edge && edge_cnt <= acc_edge + WIDTH;
      chk("in_ready", 32'(bus.in_ready), 32'(!busy));
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("bcd(%0d)", e.val), 32'(bus.bcd), 32'(e.b));
          chk($sformatf("digit(%0d)", e.val), 32'(bus.digit), 32'(e.d));
          chk($sformatf("latency(%0d)", e.val), 32'(edge_cnt - e.edge_n), 32'(LAT));
          last_bcd = e.b;
          last_digit = e.d;
        end
      end else begin
        chk("done_level", 32'(bus.done), 32'd0);
        chk("bcd_hold", 32'(bus.bcd), 32'(last_bcd));
        chk("digit_hold", 32'(bus.digit), 32'(last_digit));
      end
    end
  end

  initial begin
    int w;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.bin = '0;
    bus.lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bcd", 32'(bus.bcd), 32'h000);
    chk("rst_digit", 32'(bus.digit), 32'hFFF);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;
    mon_en = 1;
    @(posedge clk); #2;

    // Directed values, including back-to-back 42 then 199 with in_valid held.
    send(255, 0);
    send(7, 1);
    send(0, 1);
    send(100, 1);
    send(100, 0);
    send(42, 1);
    send(42, 0);
    send(199, 0);
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;

    // Abort a conversion of 128 with reset at its fourth CONVERT edge.
    send(128, 0);
    bus.in_valid = 1'b0;
    bus.bin = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    @(posedge clk); #2;
    sb.delete();
    have_acc = 0;
    last_bcd = 12'h000;
    last_digit = 12'hFFF;
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bcd", 32'(bus.bcd), 32'h000);
    chk("abort_digit", 32'(bus.digit), 32'hFFF);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    send(128, 1);
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2;

    // Exhaustive sweep, back-to-back.
    for (int v = 0; v < 256; v++) begin
      for (int lz = 0; lz < 2; lz++) send(v, lz[0]);
    end

    // Random values with random gaps and garbage on idle inputs.
    for (int n = 0; n < 200; n++) begin
      send(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        bus.bin = 8'($urandom_range(0, 255));
        bus.lz_blank = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #2;
      end
    end
    bus.in_valid = 1'b0;

    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(posedge clk);
      w++;
    end
    #2;
    chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
